// File: rtl/bch_31_pkg.sv
// Shared widths, generator polynomial and types for the BCH(31,20) encoder and its
// transmit scheduler.
package bch_31_pkg;

  localparam int MSG_W = 20;
  localparam int CW_W  = 31;
  localparam int PAR_W = CW_W - MSG_W;

  // g(x) = x^11+x^8+x^7+x^5+x^4+x^3+x+1 = (x+1) * BCH(31,21) generator; x^11 implicit
  localparam logic [PAR_W-1:0] GEN_POLY = 11'h1BB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } sched_state_t;

  typedef struct packed {
    logic             valid;
    logic [MSG_W-1:0] msg;
  } msg_req_t;

  typedef struct packed {
    logic valid;
    logic data;
    logic sof;
    logic eof;
    logic src;
  } tx_beat_t;

endpackage

// File: rtl/bch_31_encoder.sv
// Combinational systematic BCH(31,20) encoder: codeword = {msg, msg*x^11 mod g(x)}.
module bch_31_encoder
  import bch_31_pkg::*;
(
  input  logic [MSG_W-1:0] msg,
  output logic [CW_W-1:0]  codeword
);

  logic [PAR_W-1:0] rem;
  logic             fb;

  // unrolled division LFSR, message MSB first
  always_comb begin
    rem = '0;
    fb  = 1'b0;
    for (int i = MSG_W - 1; i >= 0; i--) begin
      fb  = msg[i] ^ rem[PAR_W-1];
      rem = {rem[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
    end
  end

  assign codeword = {msg, rem};

endmodule

// File: rtl/bch_rr_arb2.sv
// Two-way round-robin arbiter; 'last' is the index granted most recently.
module bch_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/bch_31_tx_sched.sv
// Round-robin scheduler sharing one BCH(31,20) encoder between two requesters and
// serialising each codeword MSB-first with sof/eof markers and tx_ready back-pressure.
module bch_31_tx_sched
  import bch_31_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [MSG_W-1:0] req0_msg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [MSG_W-1:0] req1_msg,
  output logic             req1_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic             tx_src,
  input  logic             tx_ready,
  output logic             busy
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  sched_state_t     state_q, state_d;
  logic [MSG_W-1:0] msg_q;
  logic             src_q;
  logic             pref_q;   // 0: requester 0 wins a tie next time
  logic [CW_W-1:0]  sh_q;
  logic [CW_W-1:0]  cw;
  logic [4:0]       cnt_q;
  logic [3:0]       gap_q;

  msg_req_t [1:0]   req;
  logic [1:0]       req_vld;
  logic [1:0]       grant;
  logic             last;
  logic             idle;
  tx_beat_t         beat;

  assign req[0] = {req0_valid, req0_msg};
  assign req[1] = {req1_valid, req1_msg};

  for (genvar i = 0; i < 2; i++) begin : g_vld
    assign req_vld[i] = req[i].valid;
  end

  assign last = ~pref_q;

  bch_rr_arb2 u_arb (
    .req   (req_vld),
    .last  (last),
    .grant (grant)
  );

  bch_31_encoder u_enc (
    .msg      (msg_q),
    .codeword (cw)
  );

  assign idle = (state_q == ST_IDLE);

  // gated by rst_n so every output reads 0 while reset is held
  assign req0_ready = rst_n & idle & grant[0];
  assign req1_ready = rst_n & idle & grant[1];
  assign busy       = ~idle;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req_vld) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (tx_ready && cnt_q == '0) state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q  <= '0;
      src_q  <= 1'b0;
      pref_q <= 1'b0;
      sh_q   <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|req_vld) begin
          msg_q  <= grant[1] ? req[1].msg : req[0].msg;
          src_q  <= grant[1];
          pref_q <= grant[0];
        end
        ST_LOAD: begin
          sh_q  <= cw;
          cnt_q <= 5'(CW_W - 1);
        end
        ST_SHIFT: if (tx_ready) begin
          sh_q <= {sh_q[CW_W-2:0], 1'b0};
          if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
          else             gap_q <= GAP_LOAD;
        end
        ST_GAP: if (gap_q != '0) gap_q <= gap_q - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    beat = '0;
    if (state_q == ST_SHIFT) begin
      beat.valid = 1'b1;
      beat.data  = sh_q[CW_W-1];
      beat.sof   = (cnt_q == 5'(CW_W - 1));
      beat.eof   = (cnt_q == '0);
      beat.src   = src_q;
    end
  end

  assign {tx_valid, tx_bit, tx_sof, tx_eof, tx_src} = beat;

endmodule

// File: tb/tb_bch_31_tx_sched.sv
// Bench for bch_31_tx_sched: directed + random traffic against a frame-level model,
// one DUT with no gap and one with GAP_CYCLES=3.
module tb_bch_31_tx_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        r0v, r1v, r0r, r1r, txv, txb, sof, eof, src, trdy, busy;
  logic [19:0] r0m, r1m;
  logic        g0v, g1v, g0r, g1r, g_txv, g_txb, g_sof, g_eof, g_src, g_trdy, g_busy;
  logic [19:0] g0m, g1m;

  bch_31_tx_sched #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_msg(r0m), .req0_ready(r0r),
    .req1_valid(r1v), .req1_msg(r1m), .req1_ready(r1r),
    .tx_valid(txv), .tx_bit(txb), .tx_sof(sof), .tx_eof(eof), .tx_src(src),
    .tx_ready(trdy), .busy(busy)
  );

  bch_31_tx_sched #(.GAP_CYCLES(3)) dut_g (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(g0v), .req0_msg(g0m), .req0_ready(g0r),
    .req1_valid(g1v), .req1_msg(g1m), .req1_ready(g1r),
    .tx_valid(g_txv), .tx_bit(g_txb), .tx_sof(g_sof), .tx_eof(g_eof), .tx_src(g_src),
    .tx_ready(g_trdy), .busy(g_busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference encoder: long division of msg*x^11 by g(x) = 0x9BB
  function automatic bit [30:0] ref_cw(input bit [19:0] m);
    bit [30:0] r;
    r = {m, 11'b0};
    for (int i = 30; i >= 11; i--)
      if (r[i]) r = r ^ (31'(12'h9BB) << (i - 11));
    return {m, r[10:0]};
  endfunction

  // frame-level model: pending load, beats left to send, gap cycles left
  typedef struct {
    bit        load;
    int        beats;
    int        gap;
    bit [30:0] cw;
    bit        src;
    bit        pref;
  } mdl_t;

  typedef struct {
    bit rdy0, rdy1, v, b, sof, eof, src, busy;
  } exp_t;

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.load = 0; m.beats = 0; m.gap = 0; m.cw = '0; m.src = 0; m.pref = 0;
    return m;
  endfunction

  function automatic void mdl_eval(input mdl_t m, input int gapc, input bit v0, input bit v1,
                                   input bit [19:0] m0, input bit [19:0] m1, input bit tr,
                                   output exp_t e, output mdl_t n);
    bit idle, any, g1;
    e = '{default: 0};
    n = m;
    idle = !m.load && m.beats == 0 && m.gap == 0;
    any  = v0 | v1;
    g1   = (v0 && v1) ? m.pref : v1;
    e.busy = !idle;
    if (idle && any) begin e.rdy0 = !g1; e.rdy1 = g1; end
    if (m.beats > 0) begin
      e.v = 1; e.b = m.cw[m.beats-1]; e.sof = (m.beats == 31); e.eof = (m.beats == 1); e.src = m.src;
    end
    if (idle && any) begin
      n.load = 1; n.cw = ref_cw(g1 ? m1 : m0); n.src = g1; n.pref = !g1;
    end else if (m.load) begin
      n.load = 0; n.beats = 31;
    end else if (m.beats > 0) begin
      if (tr) begin
        n.beats = m.beats - 1;
        if (n.beats == 0) n.gap = gapc;
      end
    end else if (m.gap > 0) begin
      n.gap = m.gap - 1;
    end
  endfunction

  task automatic cmp(input string p, input exp_t e, input logic a0, input logic a1, input logic v,
                     input logic b, input logic s, input logic eo, input logic sr, input logic bu);
    chk({p, "_ready0"}, a0, e.rdy0);
    chk({p, "_ready1"}, a1, e.rdy1);
    chk({p, "_tx_valid"}, v, e.v);
    chk({p, "_tx_bit"}, b, e.b);
    chk({p, "_tx_sof"}, s, e.sof);
    chk({p, "_tx_eof"}, eo, e.eof);
    chk({p, "_tx_src"}, sr, e.src);
    chk({p, "_busy"}, bu, e.busy);
  endtask

  mdl_t      ma, mg, na, ng;
  exp_t      ea, eg;
  bit        hs0, hs1, g_hs, rr_on;
  int        nb_a, g_eof_cyc, g_acc_cyc;
  logic [30:0] acc_a;
  int        rr_cyc[$];
  bit        rr_src[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      ma = mdl_rst(); mg = mdl_rst();
      nb_a = 0; acc_a = '0; g_eof_cyc = -1; g_acc_cyc = -1;
      hs0 = 0; hs1 = 0; g_hs = 0;
    end else begin
      mdl_eval(ma, 0, r0v, r1v, r0m, r1m, trdy, ea, na);
      cmp("a", ea, r0r, r1r, txv, txb, sof, eof, src, busy);
      if (txv && trdy) begin
        acc_a = {acc_a[29:0], txb};
        nb_a++;
        if (eof) begin
          chk("a_frame_len", nb_a, 31);
          chk("a_frame_cw", acc_a, ma.cw);
          nb_a = 0;
        end
      end
      if (rr_on && (r0r || r1r)) begin
        rr_cyc.push_back(cyc);
        rr_src.push_back(r1r);
      end
      hs0 = ea.rdy0; hs1 = ea.rdy1;
      ma = na;

      mdl_eval(mg, 3, g0v, g1v, g0m, g1m, g_trdy, eg, ng);
      cmp("g", eg, g0r, g1r, g_txv, g_txb, g_sof, g_eof, g_src, g_busy);
      if (g0r) begin
        if (g_eof_cyc >= 0) chk("g_eof_to_ready", cyc - g_eof_cyc, 4);
        if (g_acc_cyc >= 0) chk("g_accept_period", cyc - g_acc_cyc, 36);
        g_acc_cyc = cyc;
      end
      if (g_txv && g_eof && g_trdy) g_eof_cyc = cyc;
      g_hs = eg.rdy0;
      mg = ng;
    end
  end

  // gap DUT: requester 0 always valid, fresh message after each accept
  always @(posedge clk) begin
    #1;
    if (g_hs) g0m = 20'($urandom);
  end

  task automatic chk_zero(input string p);
    chk({p, "_ready0"}, r0r, 0);  chk({p, "_ready1"}, r1r, 0);
    chk({p, "_tx_valid"}, txv, 0); chk({p, "_tx_bit"}, txb, 0);
    chk({p, "_tx_sof"}, sof, 0);  chk({p, "_tx_eof"}, eof, 0);
    chk({p, "_tx_src"}, src, 0);  chk({p, "_busy"}, busy, 0);
    chk({p, "_g_ready0"}, g0r, 0); chk({p, "_g_tx_valid"}, g_txv, 0);
    chk({p, "_g_tx_eof"}, g_eof, 0); chk({p, "_g_busy"}, g_busy, 0);
  endtask

  task automatic wait_hs(input bit which);
    int k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (!(which ? hs1 : hs0) && k < 300);
    if (!(which ? hs1 : hs0)) chk("timeout_handshake", 0, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while ((ma.load || ma.beats != 0) && k < 300);
    if (ma.load || ma.beats != 0) chk("timeout_idle", 0, 1);
  endtask

  task automatic wait_beats(input int b);
    int k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (ma.beats != b && k < 300);
    if (ma.beats != b) chk("timeout_beat", 0, 1);
  endtask

  task automatic send(input bit which, input logic [19:0] m);
    @(posedge clk); #1;
    if (which) begin r1v = 1; r1m = m; end
    else       begin r0v = 1; r0m = m; end
    wait_hs(which);
    @(posedge clk); #1;
    if (which) r1v = 0; else r0v = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    r0v = 1; r1v = 1; r0m = '0; r1m = '0; trdy = 1; rr_on = 0;
    g0v = 1; g1v = 0; g0m = 20'h0F0F0; g1m = '0; g_trdy = 1;
    #12;
    chk_zero("reset");
    r0v = 0; r1v = 0;
    @(posedge clk); #1 rst_n = 1;

    // single message, then all-zero message on the other requester
    send(0, 20'hAAAAA);
    wait_idle();
    send(1, 20'h00000);
    wait_idle();

    // round-robin with both requesters held valid
    @(posedge clk); #1;
    rr_on = 1; r0v = 1; r1v = 1; r0m = 20'h12345; r1m = 20'h54321;
    begin
      int k = 0;
      do begin @(negedge clk); #1; k++; end while (rr_src.size() < 4 && k < 400);
    end
    @(posedge clk); #1;
    r0v = 0; r1v = 0; rr_on = 0;
    chk("rr_grant_count", rr_src.size(), 4);
    for (int i = 0; i < rr_src.size() && i < 4; i++) begin
      chk("rr_grant_src", rr_src[i], i % 2);
      if (i > 0) chk("rr_accept_spacing", rr_cyc[i] - rr_cyc[i-1], 33);
    end
    wait_idle();

    // back-pressure: stall 5 cycles while beat 10 is presented
    send(0, 20'($urandom));
    wait_beats(22);
    trdy = 0;
    repeat (5) @(posedge clk);
    #1 trdy = 1;
    wait_idle();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (hs0) begin r0v = 1'($urandom_range(0, 1)); r0m = 20'($urandom); end
      else if (!r0v && $urandom_range(0, 2) == 0) begin r0v = 1; r0m = 20'($urandom); end
      if (hs1) begin r1v = 1'($urandom_range(0, 1)); r1m = 20'($urandom); end
      else if (!r1v && $urandom_range(0, 2) == 0) begin r1v = 1; r1m = 20'($urandom); end
      trdy = ($urandom_range(0, 3) != 0);
    end
    trdy = 1;
    begin
      int k = 0;
      while ((r0v || r1v) && k < 400) begin
        @(posedge clk); #1; k++;
        if (hs0) r0v = 0;
        if (hs1) r1v = 0;
      end
      if (r0v || r1v) chk("timeout_drain", 0, 1);
    end
    wait_idle();

    // reset while beat 15 is on the line
    send(1, 20'($urandom));
    wait_beats(17);
    r0v = 1; r1v = 1; r0m = 20'h13579; r1m = 20'h2468A;
    rst_n = 0;
    #1;
    chk_zero("reset_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk); #1;
    chk("rst_first_grant", {r1r, r0r}, 2'b01);
    @(posedge clk); #1;
    r0v = 0;
    wait_hs(1);
    @(posedge clk); #1;
    r1v = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_31_tx_sched.md
# bch_31_tx_sched

Two-requester scheduler and serializer for the BCH(31,20) encoder. It arbitrates round-robin between two message sources and shares one combinational `bch_31_encoder` instance between them. It registers each resulting 31-bit codeword and streams it MSB-first onto a single-bit transmit port with frame markers and downstream back-pressure. It sits between the message producers and the serial line driver.

## Interface
- `GAP_CYCLES`, default 0: idle cycles forced between the end of one frame and the next accept window (0 to 15).
- `clk`  in  1  single clock domain, all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a message.
- `req0_msg`  in  20  requester 0 message; must be stable while valid.
- `req0_ready`  out  1  requester 0 message accepted this cycle.
- `req1_valid`, `req1_msg`, `req1_ready`: same as requester 0, for requester 1.
- `tx_valid`  out  1  `tx_bit` is a valid codeword bit.
- `tx_bit`  out  1  current codeword bit, MSB (bit 30) first.
- `tx_sof`  out  1  high with bit 30 of a frame.
- `tx_eof`  out  1  high with bit 0 of a frame.
- `tx_src`  out  1  requester index that owns the current frame.
- `tx_ready`  in  1  downstream accepts `tx_bit` this cycle.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last time wins. After reset, requester 0 is preferred.
  - `reqN_ready = (state==IDLE) & grant[N]`. Ready may depend combinationally on valid. Exactly one ready is high at a time, and only for one cycle.
  - On handshake: latch the message into `msg_q`, set `src_q`, update the RR pointer, go to LOAD.
- **LOAD**
  - `bch_31_encoder.msg` is driven from `msg_q`.
  - Capture the codeword into shift register `sh_q[30:0]`.
  - Set `cnt_q` to 30, go to SHIFT.
- **SHIFT**
  - Drive `tx_valid=1`, `tx_bit=sh_q[30]`, `tx_sof=(cnt_q==30)`, `tx_eof=(cnt_q==0)`, `tx_src=src_q`.
  - On `tx_ready`: shift `sh_q` left by 1 and decrement `cnt_q`.
  - On `tx_ready` with `cnt_q==0`: go to GAP if `GAP_CYCLES>0`, otherwise go to IDLE.
  - Without `tx_ready`, all outputs and state hold.
- **GAP**: count `GAP_CYCLES` cycles with all `tx_*` low, then go to IDLE.
- Width rules:
  - `cnt_q` is 5 bits and never wraps below 0.
  - The gap counter is 4 bits.
- Reset:
  - Asynchronous assertion clears every flop. Any frame in flight is aborted; no partial eof is emitted.
  - Reset value of every output is 0.
  - The RR pointer resets to prefer requester 0.
- `tx_bit`, `tx_sof`, `tx_eof` and `tx_src` are 0 whenever `tx_valid` is 0.

## Timing
- Handshake at edge N, then LOAD during cycle N+1, then the first `tx_valid` beat in cycle N+2.
- A frame is exactly 31 `tx_valid` beats accepted by `tx_ready`. Stalls stretch the frame without dropping or duplicating bits.
- Minimum accept-to-accept period with `tx_ready` tied high is 33 + `GAP_CYCLES` cycles.
- The next `reqN_ready` can rise in the cycle after the eof beat is accepted (`GAP_CYCLES=0`).
- Valid arriving during LOAD, SHIFT or GAP waits; ready stays 0.

## Structure
- Shared package `bch_31_pkg`:
  - `MSG_W=20`, `CW_W=31`.
  - `sched_state_t` enum.
  - `bch_31_encoder` takes its widths from this package as well.
- Sub-modules:
  - Instantiate the existing `bch_31_encoder` unchanged.
  - Round-robin grant logic is a natural sub-module, `bch_rr_arb2` (2 requests, `last` input, one-hot grant).

## Test plan
- **Single message:** req0 sends `msg=20'hAAAAA`, `tx_ready=1`.
  - `req0_ready` pulses once.
  - `tx_valid` rises 2 cycles later.
  - 31 bits appear MSB-first and equal the reference encoder output for `20'hAAAAA`.
  - `tx_sof` on beat 1, `tx_eof` on beat 31, `tx_src=0`, `busy` falls after eof.
- **Zero message:** `msg=20'h00000` produces 31 zero bits with correct sof/eof.
- **Round-robin:** both requesters hold valid, `req0_msg=20'h12345`, `req1_msg=20'h54321`.
  - Grants go 0,1,0,1 and `tx_src` matches.
  - Accepts are spaced 33 cycles apart.
- **Back-pressure:** `tx_ready` is low for 5 cycles at beat 10.
  - `tx_bit`, `tx_sof`, `tx_eof` and `tx_src` hold.
  - Exactly 31 accepted beats, and the codeword matches the encoder.
- **Reset mid-frame:** `rst_n` goes low at beat 15.
  - All outputs are 0 immediately.
  - After release, the state is IDLE, and with both valid, requester 0 is granted first.
- **Gap:** with `GAP_CYCLES=3` and req0 continuously valid, exactly 3 idle cycles separate the eof beat and the LOAD state, so `req0_ready` rises 4 cycles after eof.
